transaction_entry: RTL

TRANSACTION_ENTRY -- requirements
Module: transaction_entry

---
 rtl/transaction_entry.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/transaction_entry.sv
// Pushbutton transaction entry: synchronizes and debounces the load/start keys,
// then sequences amount -> key -> start toward the main controller.
module transaction_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       key_load_n,
  input  logic       key_start_n,
  input  logic [7:0] switches,
  input  logic       busy,
  output logic [7:0] value_out,
  output logic       load_amount,
  output logic       load_key,
  output logic       start_signal,
  output logic [1:0] entry_state,
  output logic       error
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned RUN_W = 2;
  localparam logic [RUN_W-1:0] RUN_TIMEOUT = RUN_W'(3);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_KEY = 2'b01,
    READY    = 2'b10,
    RUN      = 2'b11
  } state_t;

  // Bit 0 is the load key, bit 1 the start key.
  logic [1:0]       sync_a, sync_b, deb, deb_prev, armed;
  logic [1:0]       sync_vld;
  logic [CNT_W-1:0] cnt [2];
  logic             load_ev_c, start_ev_c;

  // Synchronizer + debounce; a key only arms once seen released after reset,
  // so a key held through reset release never produces an event.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_a   <= 2'b11;
      sync_b   <= 2'b11;
      deb      <= 2'b11;
      deb_prev <= 2'b11;
      armed    <= 2'b00;
      sync_vld <= 2'b00;
      cnt[0]   <= '0;
      cnt[1]   <= '0;
    end else begin
      sync_a   <= {key_start_n, key_load_n};
      sync_b   <= sync_a;
      sync_vld <= {sync_vld[0], 1'b1};
      deb_prev <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] != deb[i]) begin
          if (cnt[i] == CNT_MAX) begin
            deb[i] <= sync_b[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
        if (sync_vld[1] && sync_b[i] && deb[i]) armed[i] <= 1'b1;
      end
    end
  end

  assign load_ev_c  = armed[0] & deb_prev[0] & ~deb[0];
  assign start_ev_c = armed[1] & deb_prev[1] & ~deb[1];

  state_t           state, state_nx;
  logic [7:0]       value_nx;
  logic             load_amount_nx, load_key_nx, start_nx, error_nx;
  logic             busy_seen, busy_seen_nx;
  logic [RUN_W-1:0] run_cnt, run_cnt_nx;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      value_out    <= 8'h00;
      load_amount  <= 1'b0;
      load_key     <= 1'b0;
      start_signal <= 1'b0;
      error        <= 1'b0;
      busy_seen    <= 1'b0;
      run_cnt      <= '0;
    end else begin
      state        <= state_nx;
      value_out    <= value_nx;
      load_amount  <= load_amount_nx;
      load_key     <= load_key_nx;
      start_signal <= start_nx;
      error        <= error_nx;
      busy_seen    <= busy_seen_nx;
      run_cnt      <= run_cnt_nx;
    end
  end

  // Load always wins over a simultaneous start; the start is dropped silently.
  always_comb begin
    state_nx       = state;
    value_nx       = value_out;
    load_amount_nx = 1'b0;
    load_key_nx    = 1'b0;
    start_nx       = 1'b0;
    error_nx       = error;
    busy_seen_nx   = busy_seen;
    run_cnt_nx     = run_cnt;
    case (state)
      IDLE: begin
        if (load_ev_c) begin
          if (switches != 8'h00) begin
            value_nx       = switches;
            load_amount_nx = 1'b1;
            state_nx       = WAIT_KEY;
            error_nx       = 1'b0;
          end else begin
            error_nx = 1'b1;
          end
        end else if (start_ev_c) begin
          error_nx = 1'b1;
        end
      end
      WAIT_KEY: begin
        if (load_ev_c) begin
          value_nx    = switches;
          load_key_nx = 1'b1;
          state_nx    = READY;
          error_nx    = 1'b0;
        end else if (start_ev_c) begin
          error_nx = 1'b1;
        end
      end
      READY: begin
        if (load_ev_c) begin
          value_nx    = switches;
          load_key_nx = 1'b1;
        end else if (start_ev_c) begin
          if (busy) begin
            error_nx = 1'b1;
          end else begin
            start_nx     = 1'b1;
            state_nx     = RUN;
            busy_seen_nx = 1'b0;
            run_cnt_nx   = '0;
          end
        end
      end
      RUN: begin
        if (busy) begin
          busy_seen_nx = 1'b1;
        end else if (busy_seen) begin
          state_nx = IDLE;
        end else if (run_cnt == RUN_TIMEOUT) begin
          state_nx = IDLE;
          error_nx = 1'b1;
        end else begin
          run_cnt_nx = run_cnt + RUN_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign entry_state = state;

endmodule
